// File: rtl/alu_op_sequencer_if.sv
// Bus bundle for alu_op_sequencer: instruction request handshake, register-file
// read/write port, ALU operand/result port and retire/status outputs.
// Optional macro ALU_SEQ_IMM_EN adds the immediate-operand request fields.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  // Instruction request
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [REG_AW-1:0] req_rd;
  logic [REG_AW-1:0] req_rn;
  logic [REG_AW-1:0] req_rm;
  logic [1:0]        req_sh;
  logic              req_wb;
  logic              req_setf;
`ifdef ALU_SEQ_IMM_EN
  logic              req_use_imm;
  logic [DATA_W-1:0] req_imm;
`endif
  // Register file
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  // ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_z;
  // Status / retire
  logic [2:0]        status;
  logic              done;

  // Sequencer side
  modport slave (
`ifdef ALU_SEQ_IMM_EN
    input  req_use_imm, req_imm,
`endif
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_sh, req_wb, req_setf,
    input  rf_rd_data, alu_out, alu_z,
    output req_ready, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output alu_a, alu_b, alu_op, status, done
  );

  // Requester / datapath side
  modport master (
`ifdef ALU_SEQ_IMM_EN
    output req_use_imm, req_imm,
`endif
    output req_valid, req_op, req_rd, req_rn, req_rm, req_sh, req_wb, req_setf,
    output rf_rd_data, alu_out, alu_z,
    input  req_ready, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  alu_a, alu_b, alu_op, status, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU issue controller: reads rn/rm through one register-file read
// port, shifts B, drives the ALU, captures result/flags, writes back and keeps
// the architectural status register.
// Optional macro ALU_SEQ_IMM_EN: shifted immediate replaces the rm operand.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  alu_op_sequencer_if.slave  io_bus
);

  typedef enum logic [2:0] {StIdle, StReadA, StReadB, StExec, StWb} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic              w_accept;
  logic              r_live;
  logic [1:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rn;
  logic [REG_AW-1:0] r_rm;
  logic [1:0]        r_sh;
  logic              r_wb;
  logic              r_setf;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [2:0]        r_flags;
  logic [2:0]        r_status;
  logic              w_req_use_imm;
  logic              w_use_imm;

`ifdef ALU_SEQ_IMM_EN
  logic r_use_imm;
  assign w_req_use_imm = io_bus.req_use_imm;
  assign w_use_imm     = r_use_imm;
`else
  assign w_req_use_imm = 1'b0;
  assign w_use_imm     = 1'b0;
`endif

  // B-operand shifter: none / LSL1 / LSR1 zero-fill / ASR1 sign-fill
  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] d,
                                                input logic [1:0]        sh);
    logic [DATA_W-1:0] y;
    case (sh)
      2'b01:   y = {d[DATA_W-2:0], 1'b0};
      2'b10:   y = {1'b0, d[DATA_W-1:1]};
      2'b11:   y = {d[DATA_W-1], d[DATA_W-1:1]};
      default: y = d;
    endcase
    return y;
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state outputs
  always_comb begin
    w_state_next      = r_state;
    w_accept          = 1'b0;
    io_bus.req_ready  = 1'b0;
    io_bus.rf_rd_addr = '0;
    io_bus.rf_wr_en   = 1'b0;
    io_bus.done       = 1'b0;
    case (r_state)
      StIdle: begin
        io_bus.req_ready = r_live;
        if (io_bus.req_valid && r_live) begin
          w_accept = 1'b1;
          // not-B needs no A operand, so READ_A is skipped
          if (io_bus.req_op == 2'b11) begin
            w_state_next = w_req_use_imm ? StExec : StReadB;
          end else begin
            w_state_next = StReadA;
          end
        end
      end
      StReadA: begin
        io_bus.rf_rd_addr = r_rn;
        w_state_next      = w_use_imm ? StExec : StReadB;
      end
      StReadB: begin
        io_bus.rf_rd_addr = r_rm;
        w_state_next      = StExec;
      end
      StExec: begin
        w_state_next = StWb;
      end
      StWb: begin
        io_bus.done     = 1'b1;
        io_bus.rf_wr_en = r_wb;
        w_state_next    = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Request latch, operand capture, result capture and status update
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_live    <= 1'b0;
      r_op      <= '0;
      r_rd      <= '0;
      r_rn      <= '0;
      r_rm      <= '0;
      r_sh      <= '0;
      r_wb      <= 1'b0;
      r_setf    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_flags   <= '0;
      r_status  <= '0;
`ifdef ALU_SEQ_IMM_EN
      r_use_imm <= 1'b0;
`endif
    end else begin
      // req_ready comes up on the first edge after reset release
      r_live <= 1'b1;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op   <= io_bus.req_op;
            r_rd   <= io_bus.req_rd;
            r_rn   <= io_bus.req_rn;
            r_rm   <= io_bus.req_rm;
            r_sh   <= io_bus.req_sh;
            r_wb   <= io_bus.req_wb;
            r_setf <= io_bus.req_setf;
            // A stays 0 for not-B; other ops overwrite it in READ_A
            r_a    <= '0;
`ifdef ALU_SEQ_IMM_EN
            r_use_imm <= io_bus.req_use_imm;
            if (io_bus.req_use_imm) begin
              r_b <= f_shift(io_bus.req_imm, io_bus.req_sh);
            end
`endif
          end
        end
        StReadA: r_a <= io_bus.rf_rd_data;
        StReadB: r_b <= f_shift(io_bus.rf_rd_data, r_sh);
        StExec: begin
          r_res   <= io_bus.alu_out;
          r_flags <= io_bus.alu_z;
        end
        StWb: begin
          // overflow is only architecturally meaningful for sub
          if (r_setf) begin
            r_status <= {r_flags[2], r_flags[1] & (r_op == 2'b01), r_flags[0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.rf_wr_addr = r_rd;
  assign io_bus.rf_wr_data = r_res;
  assign io_bus.alu_a      = r_a;
  assign io_bus.alu_b      = r_b;
  assign io_bus.alu_op     = r_op;
  assign io_bus.status     = r_status;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural register file and ALU.
module tb_alu_op_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_op_sequencer_if #(.DATA_W(16), .REG_AW(3)) bus ();

  alu_op_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .io_bus    (bus)
  );

  always #5 clk = ~clk;

  // Register file model with a bench-side preload port
  logic [15:0] rf [8];
  logic        pre_en;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
  end

  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  // ALU model: flags {N, V, Z}
  logic [15:0] alu_y;
  logic        alu_v;
  always_comb begin
    alu_y = '0;
    alu_v = 1'b0;
    case (bus.alu_op)
      2'b00: begin
        alu_y = bus.alu_a + bus.alu_b;
        alu_v = (bus.alu_a[15] == bus.alu_b[15]) && (alu_y[15] != bus.alu_a[15]);
      end
      2'b01: begin
        alu_y = bus.alu_a - bus.alu_b;
        alu_v = (bus.alu_a[15] != bus.alu_b[15]) && (alu_y[15] != bus.alu_a[15]);
      end
      2'b10:   alu_y = bus.alu_a & bus.alu_b;
      default: alu_y = ~bus.alu_b;
    endcase
    bus.alu_out = alu_y;
    bus.alu_z   = {alu_y[15], alu_v, (alu_y == 16'h0000)};
  end

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk); #1;
    pre_en   = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [1:0] sh, input logic wb,
                           input logic setf);
    bus.req_op   = op;
    bus.req_rd   = rd;
    bus.req_rn   = rn;
    bus.req_rm   = rm;
    bus.req_sh   = sh;
    bus.req_wb   = wb;
    bus.req_setf = setf;
  endtask

  // Issue one instruction and run it to retire; reports latency (0 = timeout),
  // whether rn was ever put on the read port, and write-port values at done.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic wb,
                       input logic setf, output int lat, output bit saw_rn,
                       output logic wr_en, output logic [2:0] wr_addr);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    drive_req(op, rd, rn, rm, sh, wb, setf);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // scramble fields; the latched copy must be used
    drive_req(~op, ~rd, ~rn, ~rm, ~sh, ~wb, ~setf);
    lat     = 0;
    saw_rn  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    for (int n = 1; n <= 10; n++) begin
      if (bus.rf_rd_addr == rn) saw_rn = 1'b1;
      if (bus.done) begin
        lat     = n;
        wr_en   = bus.rf_wr_en;
        wr_addr = bus.rf_wr_addr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.done !== 1'b0 || bus.rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b done=%b wr_en=%b want 0 0 0",
               bus.req_ready, bus.done, bus.rf_wr_en);
    end
    checks++;
    if (bus.status !== 3'b000 || bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 ||
        bus.alu_op !== 2'b00 || bus.rf_rd_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: status=%b a=%h b=%h op=%b rd_addr=%0d want all 0",
               bus.status, bus.alu_a, bus.alu_b, bus.alu_op, bus.rf_rd_addr);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_add();
    int lat; bit saw; logic we; logic [2:0] wa;
    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0003);
    issue(2'b00, 3'd3, 3'd1, 3'd2, 2'b00, 1'b1, 1'b1, lat, saw, we, wa);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if (we !== 1'b1 || wa !== 3'd3) begin
      errors++; $display("FAIL add_wr: en=%b addr=%0d want 1 3", we, wa);
    end
    checks++;
    if (rf[3] !== 16'h0008) begin errors++; $display("FAIL add_r3: got %h want 0008", rf[3]); end
    checks++;
    if (bus.status !== 3'b000) begin
      errors++; $display("FAIL add_status: got %b want 000", bus.status);
    end
  endtask

  task automatic test_sub_overflow();
    int lat; bit saw; logic we; logic [2:0] wa;
    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'hFFFF);
    set_reg(3'd4, 16'h1234);
    issue(2'b01, 3'd4, 3'd1, 3'd2, 2'b00, 1'b0, 1'b1, lat, saw, we, wa);
    checks++;
    if (lat !== 4 || we !== 1'b0) begin
      errors++; $display("FAIL sub_nowb: lat=%0d wr_en=%b want 4 0", lat, we);
    end
    checks++;
    if (rf[4] !== 16'h1234) begin errors++; $display("FAIL sub_r4: got %h want 1234", rf[4]); end
    checks++;
    if (bus.status !== 3'b110) begin
      errors++; $display("FAIL sub_status: got %b want 110", bus.status);
    end
  endtask

  task automatic test_not_shift();
    int lat; bit saw; logic we; logic [2:0] wa;
    set_reg(3'd4, 16'h8002);
    issue(2'b11, 3'd5, 3'd6, 3'd4, 2'b11, 1'b1, 1'b0, lat, saw, we, wa);
    checks++;
    if (lat !== 3 || saw !== 1'b0) begin
      errors++; $display("FAIL not_asr_path: lat=%0d saw_rn=%b want 3 0", lat, saw);
    end
    checks++;
    if (bus.alu_b !== 16'hC001 || bus.alu_a !== 16'h0000) begin
      errors++; $display("FAIL not_asr_ops: a=%h b=%h want 0000 C001", bus.alu_a, bus.alu_b);
    end
    checks++;
    if (rf[5] !== 16'h3FFE) begin errors++; $display("FAIL not_asr_r5: got %h want 3FFE", rf[5]); end
    issue(2'b11, 3'd5, 3'd6, 3'd4, 2'b10, 1'b1, 1'b0, lat, saw, we, wa);
    checks++;
    if (rf[5] !== 16'hBFFE) begin errors++; $display("FAIL not_lsr_r5: got %h want BFFE", rf[5]); end
    checks++;
    if (bus.status !== 3'b110) begin
      errors++; $display("FAIL not_status_held: got %b want 110", bus.status);
    end
  endtask

  task automatic test_and_lsl();
    int lat; bit saw; logic we; logic [2:0] wa;
    set_reg(3'd1, 16'h00F0);
    set_reg(3'd2, 16'h0F0F);
    issue(2'b10, 3'd3, 3'd1, 3'd2, 2'b01, 1'b1, 1'b0, lat, saw, we, wa);
    checks++;
    if (rf[3] !== 16'h0010) begin errors++; $display("FAIL and_r3: got %h want 0010", rf[3]); end
    checks++;
    if (bus.status !== 3'b110) begin
      errors++; $display("FAIL and_status_held: got %b want 110", bus.status);
    end
  endtask

  task automatic test_flags();
    int lat; bit saw; logic we; logic [2:0] wa;
    // add overflow: ALU reports V but status must drop it
    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'h0001);
    issue(2'b00, 3'd5, 3'd1, 3'd2, 2'b00, 1'b1, 1'b1, lat, saw, we, wa);
    checks++;
    if (rf[5] !== 16'h8000 || bus.status !== 3'b100) begin
      errors++;
      $display("FAIL add_vforce: r5=%h status=%b want 8000 100", rf[5], bus.status);
    end
    // rd == rn == rm, result zero
    issue(2'b01, 3'd1, 3'd1, 3'd1, 2'b00, 1'b1, 1'b1, lat, saw, we, wa);
    checks++;
    if (rf[1] !== 16'h0000 || bus.status !== 3'b001) begin
      errors++;
      $display("FAIL sub_self_zero: r1=%h status=%b want 0000 001", rf[1], bus.status);
    end
  endtask

  task automatic test_back_to_back();
    int done_n; int acc_n; int lat2; int guard;
    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0003);
    drive_req(2'b00, 3'd3, 3'd1, 3'd2, 2'b00, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    // second request presented immediately and held
    drive_req(2'b00, 3'd7, 3'd3, 3'd3, 2'b00, 1'b1, 1'b0);
    done_n = 0;
    acc_n  = 0;
    for (int n = 1; n <= 12; n++) begin
      if (bus.req_ready) begin acc_n = n; break; end
      if (bus.done) done_n = n;
      @(posedge clk); #1;
    end
    checks++;
    if (done_n !== 4 || acc_n !== 5) begin
      errors++; $display("FAIL b2b_accept: done@%0d ready@%0d want 4 5", done_n, acc_n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat2  = 0;
    guard = 0;
    while (lat2 == 0 && guard < 10) begin
      guard++;
      if (bus.done) lat2 = guard;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    checks++;
    if (lat2 !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat2); end
    checks++;
    if (rf[3] !== 16'h0008 || rf[7] !== 16'h0010) begin
      errors++; $display("FAIL b2b_dep: r3=%h r7=%h want 0008 0010", rf[3], rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit saw; logic we; logic [2:0] wa; bit wr_seen;
    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'hFFFF);
    set_reg(3'd6, 16'hABCD);
    drive_req(2'b00, 3'd6, 3'd1, 3'd2, 2'b00, 1'b1, 1'b1);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;  // in EXEC
    #1;
    checks++;
    if (bus.status !== 3'b000 || bus.rf_wr_en !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: status=%b wr_en=%b ready=%b want 000 0 0",
               bus.status, bus.rf_wr_en, bus.req_ready);
    end
    wr_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rf_wr_en || bus.done) wr_seen = 1'b1;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || wr_seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: ready=%b wr_seen=%b want 1 0", bus.req_ready, wr_seen);
    end
    checks++;
    if (rf[6] !== 16'hABCD) begin errors++; $display("FAIL rst_r6: got %h want ABCD", rf[6]); end
    issue(2'b01, 3'd6, 3'd1, 3'd2, 2'b00, 1'b1, 1'b1, lat, saw, we, wa);
    checks++;
    if (lat !== 4 || rf[6] !== 16'h8000 || bus.status !== 3'b110) begin
      errors++;
      $display("FAIL rst_after: lat=%0d r6=%h status=%b want 4 8000 110",
               lat, rf[6], bus.status);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    checks   = 0;
    errors   = 0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.req_valid = 1'b0;
    drive_req(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
`ifdef ALU_SEQ_IMM_EN
    bus.req_use_imm = 1'b0;
    bus.req_imm     = '0;
`endif
    test_reset();
    test_add();
    test_sub_overflow();
    test_not_shift();
    test_and_lsl();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
